// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants for the iterative divider
package div_unit_pkg;

   // Divider FSM encodings
   localparam logic [1:0] DivFree   = 2'b00;
   localparam logic [1:0] DivByZero = 2'b01;
   localparam logic [1:0] DivOn     = 2'b10;
   localparam logic [1:0] DivEnd    = 2'b11;

   // Handshake levels
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-side request/response bundle for the divider
interface div_unit_if #(
   parameter int DATA_W = 32
);
   import div_unit_pkg::*;

   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   // EX stage drives the request and watches for the result
   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   // Divider consumes the request and returns {remainder, quotient}
   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );

endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider for DIV/DIVU
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

   // Working register layout: [2W:W] partial remainder, [W-1:0] dividend
   // bits still to be consumed, with quotient bits shifting in at bit 0.
   logic [1:0]            state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic [2*DATA_W:0]     work_q,    work_d;
   logic [DATA_W-1:0]     divisor_q, divisor_d;
   logic                  quo_neg_q, quo_neg_d;
   logic                  rem_neg_q, rem_neg_d;
   logic [2*DATA_W-1:0]   result_q,  result_d;
   logic                  ready_q,   ready_d;

   logic [2*DATA_W:0]     work_step;
   logic [DATA_W-1:0]     quo_raw;
   logic [DATA_W-1:0]     rem_raw;

   // Magnitude of an operand; unsigned mode passes it through untouched.
   // The most negative value maps onto itself, which read unsigned is
   // exactly its magnitude.
   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x,
                                             input logic              sgn);
      return (sgn && x[DATA_W-1]) ? (~x + 1'b1) : x;
   endfunction

   // One restoring step: bring the next dividend bit into the partial
   // remainder, subtract the divisor when it fits, record the quotient bit.
   function automatic logic [2*DATA_W:0] div_step(input logic [2*DATA_W:0] w,
                                                  input logic [DATA_W-1:0] d);
      logic [DATA_W+1:0] part;
      logic [DATA_W:0]   rem_new;
      logic              q_bit;
      part    = {w[2*DATA_W:DATA_W], w[DATA_W-1]};
      q_bit   = (part >= {2'b00, d});
      // The true difference is below the divisor, so W+1 bits hold it
      rem_new = q_bit ? (part[DATA_W:0] - {1'b0, d}) : part[DATA_W:0];
      return {rem_new, w[DATA_W-2:0], q_bit};
   endfunction

   assign work_step = div_step(work_q, divisor_q);
   assign quo_raw   = work_step[DATA_W-1:0];
   assign rem_raw   = work_step[2*DATA_W-1:DATA_W];

   // Next-state logic for the divider FSM and datapath
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;
      ready_d   = ready_q;

      case (state_q)
         DivFree: begin
            result_d = '0;
            ready_d  = DivResultNotReady;
            // A flush in the same cycle as the request cancels it
            if (bus.start_i == DivStart && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  state_d = DivByZero;
               end else begin
                  state_d   = DivOn;
                  cnt_d     = '0;
                  work_d    = {{(DATA_W+1){1'b0}}, mag(bus.opdata1_i, bus.signed_div_i)};
                  divisor_d = mag(bus.opdata2_i, bus.signed_div_i);
                  quo_neg_d = bus.signed_div_i &
                              (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                  rem_neg_d = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
               end
            end
         end

         DivByZero: begin
            // Zero result; ready is raised from END on the next edge
            state_d  = DivEnd;
            result_d = '0;
            ready_d  = DivResultNotReady;
         end

         DivOn: begin
            if (bus.annul_i) begin
               state_d  = DivFree;
               cnt_d    = '0;
               result_d = '0;
               ready_d  = DivResultNotReady;
            end else begin
               work_d = work_step;
               if (cnt_q == LAST_ITER) begin
                  state_d  = DivEnd;
                  result_d = {rem_neg_q ? (~rem_raw + 1'b1) : rem_raw,
                              quo_neg_q ? (~quo_raw + 1'b1) : quo_raw};
                  ready_d  = DivResultReady;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         DivEnd: begin
            if (bus.start_i == DivStop || bus.annul_i) begin
               state_d  = DivFree;
               result_d = '0;
               ready_d  = DivResultNotReady;
            end else begin
               ready_d = DivResultReady;
            end
         end

         default: begin
            state_d  = DivFree;
            result_d = '0;
            ready_d  = DivResultNotReady;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= DivResultNotReady;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed-vector bench for div_unit (32-bit and 8-bit)
module tb_div_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   div_unit_if #(.DATA_W(32)) bus32 ();
   div_unit_if #(.DATA_W(8))  bus8 ();

   div_unit #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
   div_unit #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns edges after acceptance until ready (timeout shows as 200)
   task automatic wait32(output int lat);
      int n = 0;
      while (n < 200) begin
         @(posedge clk); #1;
         n++;
         if (bus32.ready_o) break;
      end
      lat = n - 1;
   endtask

   task automatic start32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus32.signed_div_i = sgn;
      bus32.opdata1_i    = a;
      bus32.opdata2_i    = b;
      bus32.annul_i      = 1'b0;
      bus32.start_i      = 1'b1;
   endtask

   task automatic drop32(input string tag);
      @(negedge clk);
      bus32.start_i = 1'b0;
      @(posedge clk); #1;
      check({tag, "_rdy_fall"}, 64'(bus32.ready_o), 64'd0);
      check({tag, "_res_clr"},  bus32.result_o, 64'd0);
   endtask

   task automatic run32(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
      int lat;
      start32(sgn, a, b);
      wait32(lat);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res"}, bus32.result_o, exp);
      drop32(tag);
   endtask

   task automatic run8(input string tag, input logic sgn, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp);
      int n = 0;
      @(negedge clk);
      bus8.signed_div_i = sgn;
      bus8.opdata1_i    = a;
      bus8.opdata2_i    = b;
      bus8.annul_i      = 1'b0;
      bus8.start_i      = 1'b1;
      while (n < 100) begin
         @(posedge clk); #1;
         n++;
         if (bus8.ready_o) break;
      end
      check({tag, "_lat"}, 64'(n - 1), 64'd8);
      check({tag, "_res"}, 64'(bus8.result_o), 64'(exp));
      @(negedge clk);
      bus8.start_i = 1'b0;
      @(posedge clk); #1;
      check({tag, "_rdy_fall"}, 64'(bus8.ready_o), 64'd0);
   endtask

   initial begin
      int lat;
      bus32.signed_div_i = 1'b0; bus32.opdata1_i = '0; bus32.opdata2_i = '0;
      bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
      bus8.signed_div_i = 1'b0; bus8.opdata1_i = '0; bus8.opdata2_i = '0;
      bus8.start_i = 1'b0; bus8.annul_i = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_rdy", 64'(bus32.ready_o), 64'd0);
      check("reset_res", bus32.result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run32("u_100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 32);
      run32("s_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    32);
      run32("s_min_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           32);
      run32("s_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           32);
      run32("s_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},          32);
      run32("u_big_2",   1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1, 32'h7FFFFFFC},           32);
      run32("u_max_16",  1'b0, 32'hFFFFFFFF,   32'h10,         {32'hF, 32'h0FFFFFFF},           32);
      run32("u_3_10",    1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                  32);
      run32("byzero",    1'b0, 32'd5,          32'd0,          64'd0,                           2);

      // Annul on the 10th iteration edge, then restart on the next cycle
      start32(1'b0, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus32.annul_i = 1'b1;
      @(posedge clk); #1;
      check("annul_rdy", 64'(bus32.ready_o), 64'd0);
      check("annul_res", bus32.result_o, 64'd0);
      @(negedge clk);
      bus32.annul_i   = 1'b0;
      bus32.opdata1_i = 32'd9;
      bus32.opdata2_i = 32'd3;
      wait32(lat);
      check("restart_lat", 64'(lat), 64'd32);
      check("restart_res", bus32.result_o, {32'd0, 32'd3});

      // Annul while the result is held drops ready even with start high
      @(negedge clk);
      bus32.annul_i = 1'b1;
      @(posedge clk); #1;
      check("end_annul_rdy", 64'(bus32.ready_o), 64'd0);
      check("end_annul_res", bus32.result_o, 64'd0);
      @(negedge clk);
      bus32.annul_i = 1'b0;
      bus32.start_i = 1'b0;

      // Reset mid-iteration, then a fresh operation must complete normally
      start32(1'b0, 32'd1000, 32'd10);
      repeat (6) @(posedge clk);
      @(negedge clk); #2;
      rst = 1'b0;
      bus32.start_i = 1'b0;
      #1;
      check("rst_on_rdy", 64'(bus32.ready_o), 64'd0);
      check("rst_on_res", bus32.result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run32("after_rst", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 32);

      // Reset while a result is held clears outputs without a clock edge
      start32(1'b0, 32'd50, 32'd7);
      wait32(lat);
      check("pre_rst_res", bus32.result_o, {32'd1, 32'd7});
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check("rst_end_rdy", 64'(bus32.ready_o), 64'd0);
      check("rst_end_res", bus32.result_o, 64'd0);
      bus32.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      run8("w8_u_200_3", 1'b0, 8'd200, 8'd3,  {8'd2, 8'd66});
      run8("w8_s_80_1",  1'b1, 8'h80,  8'h01, {8'h00, 8'h80});
      run8("w8_s_m7_2",  1'b1, 8'hF9,  8'h02, {8'hFF, 8'hFD});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised iterative divider that lets the EX stage execute DIV/DIVU as multi-cycle operations. It replaces single-cycle HI/LO arithmetic with a start/ready handshake. The block sits beside `ex`: EX holds the pipeline stalled while the operation is in flight, then forwards `{remainder, quotient}` to `ex_mem` as the HI/LO write. It supports a configurable width, signed and unsigned modes, divide-by-zero short-circuit, and mid-operation cancel.

## Interface
- `DATA_W`, default 32: operand width, any value ≥ 4.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `opdata1_i`  in  DATA_W  dividend; sampled with `start_i`.
- `opdata2_i`  in  DATA_W  divisor; sampled with `start_i`.
- `start_i`  in  1  level request; held high by EX until `ready_o` is seen.
- `annul_i`  in  1  cancel the current operation (branch-delay/flush).
- `result_o`  out  2*DATA_W  `{remainder, quotient}`; upper half goes to HI, lower half to LO.
- `ready_o`  out  1  result valid.

## Operation
- States:
  - FREE: idle.
  - BYZERO: divisor is 0.
  - ON: iterating.
  - END: result held.
- FREE:
  - `start_i`=1 and `annul_i`=0 and divisor≠0 → ON. Latch absolute values of the operands (signed mode only), the sign flags, and clear the iteration counter.
  - Divisor=0 → BYZERO.
  - `annul_i`=1 → stay FREE; annul wins over start.
- BYZERO: unconditional → END with `result_o`=0, `ready_o`=1.
- ON:
  - Restoring division, one quotient bit per cycle, using a 2*DATA_W+1 bit working register.
  - Each cycle: compare the shifted partial remainder with the divisor, subtract if ≥, and shift in the quotient bit.
  - The counter runs 0..DATA_W-1. On the iteration with counter = DATA_W-1 → END.
  - On that transition, apply the sign fix-ups:
    - Quotient is negated if the operand signs differ (signed mode).
    - Remainder takes the sign of the dividend (signed mode).
  - Register `result_o` and set `ready_o`=1.
  - `annul_i`=1 at any ON edge → FREE, `result_o`=0, `ready_o`=0, counter cleared.
  - `start_i` dropping without `annul_i` has no effect; iteration continues.
- END:
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - `start_i`=0 or `annul_i`=1 → FREE, `result_o`=0, `ready_o`=0.
- Arithmetic rules:
  - Signed most-negative ÷ −1 gives quotient = most-negative (two's-complement wrap) and remainder 0. No exception is raised.
  - Unsigned mode uses the operands unmodified.
- Reset (any time, including mid-ON): state FREE, `result_o`=0, `ready_o`=0, counter 0, working registers 0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start sampled at edge k (FREE→ON):
  - Iterations occur at edges k+1 … k+DATA_W.
  - `ready_o` rises after edge k+DATA_W, i.e. DATA_W cycles after acceptance (32 for the default).
- Divide by zero: `ready_o` rises after edge k+2.
- `ready_o` falls one edge after `start_i` is seen low in END.
- A new start is accepted on the edge after returning to FREE; the minimum gap is one FREE cycle between operations.
- Annul sampled at edge j: state is FREE after edge j, and a new start is accepted at edge j+1.

## Structure
- Add the following to `defines.v`:
  - State encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
  - `DivResultReady`/`DivResultNotReady`.
  - `DivStart`/`DivStop`.
- One file, `div_unit`. No sub-module; the per-cycle subtract/shift step is a local function.
- Integration: EX asserts a stall request while `start_i`=1 and `ready_o`=0. The stall controller uses it to freeze `pc_reg`, `if_id` and `id_ex`.

## Test plan
- Unsigned, DATA_W=32, 100 ÷ 7 → `result_o`={32'd2, 32'd14}; `ready_o` high exactly 32 cycles after acceptance; drop `start_i` → `ready_o` low next edge.
- Signed −7 ÷ 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero, 5 ÷ 0 → `ready_o` after 2 cycles, `result_o`=0.
- Annul at the 10th ON cycle → FREE next edge, `ready_o` stays 0. Restart 9 ÷ 3 on the following cycle → {0, 3} after 32 cycles.
- Assert `rst` low mid-ON → outputs 0 immediately (asynchronous), state FREE. A new start after release completes correctly.
- DATA_W=8, unsigned 200 ÷ 3 → {8'd2, 8'd66} after 8 cycles; signed 0x80 ÷ 0x01 → {0x00, 0x80}.
